// File: rtl/aes256_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : aes256_key_expand
// Description : Iterative AES-256 key schedule. Loads a 256-bit cipher key
//               and expands it into 60 32-bit words (15 round keys), one
//               word per clock, and presents them as a packed 1920-bit bus
//               with a valid flag.
// Ports       : clk             - rising-edge clock
//               rst             - asynchronous, active-low reset
//               key             - cipher key, key[255:224] = w0 .. key[31:0] = w7
//               key_zeroize     - (AES_KEY_ZEROIZE_EN only) wipe all key material
//               key_load        - single-cycle start strobe, key sampled same edge
//               round_keys_flat - round key i at [128i+127:128i], rk0 at [127:0]
//               keys_valid      - all 60 words match the last loaded key
//               busy            - expansion in progress
// Options     : `define AES_KEY_ZEROIZE_EN adds the key_zeroize input.
// Parameters  : CLEAR_ON_LOAD   - 1: zero w8..w59 when a key is loaded
// Revision    : 1.0 - initial release
// ============================================================================
module aes256_key_expand #(
    parameter int CLEAR_ON_LOAD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [255:0]  key,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic          key_zeroize,
`endif
    input  logic          key_load,
    output logic [1919:0] round_keys_flat,
    output logic          keys_valid,
    output logic          busy
);

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [5:0] c_IDX_FIRST = 6'd8;
    localparam logic [5:0] c_IDX_LAST  = 6'd59;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // Byte at index b sits at bit offset (255-b)*8; 255-b is simply ~b.
    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        return c_SBOX[{~b, 3'b000} +: 8];
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_words [0:59];
    logic [5:0]  r_idx;
    logic        r_busy;
    logic        r_keys_valid;

    logic        w_clear;
    logic        w_load;
    logic        w_step;
    logic        w_done;
    logic        w_zeroize;
    logic [5:0]  w_prev_idx;
    logic [5:0]  w_back_idx;
    logic [31:0] w_prev;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub;
    logic [7:0]  w_rcon;
    logic [31:0] w_temp;

`ifdef AES_KEY_ZEROIZE_EN
    assign w_zeroize = key_zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register and next-state / control decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Zeroize beats load, and a load beats the in-flight step (including
    // the final w59 write), so a restart always discards the old expansion.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_done       = 1'b0;
        if (w_zeroize) begin
            w_clear      = 1'b1;
            w_next_state = IDLE;
        end else if (key_load) begin
            w_load       = 1'b1;
            w_next_state = EXPAND;
        end else if (r_state == EXPAND) begin
            w_step = 1'b1;
            if (r_idx == c_IDX_LAST) begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word recurrence: w[idx] = w[idx-8] ^ temp(w[idx-1])
    // ------------------------------------------------------------------
    assign w_prev_idx = r_idx - 6'd1;
    assign w_back_idx = r_idx - 6'd8;
    assign w_prev     = r_words[w_prev_idx];

    // RotWord only on idx%8==0; one shared set of four S-box lookups.
    assign w_sub_in = (r_idx[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sub    = {f_sbox(w_sub_in[31:24]), f_sbox(w_sub_in[23:16]),
                       f_sbox(w_sub_in[15:8]),  f_sbox(w_sub_in[7:0])};

    always_comb begin
        w_rcon = 8'h00;
        case (r_idx[5:3])
            3'd1:    w_rcon = 8'h01;
            3'd2:    w_rcon = 8'h02;
            3'd3:    w_rcon = 8'h04;
            3'd4:    w_rcon = 8'h08;
            3'd5:    w_rcon = 8'h10;
            3'd6:    w_rcon = 8'h20;
            3'd7:    w_rcon = 8'h40;
            default: w_rcon = 8'h00;
        endcase
    end

    always_comb begin
        w_temp = w_prev;
        case (r_idx[2:0])
            3'd0:    w_temp = w_sub ^ {w_rcon, 24'h000000};
            3'd4:    w_temp = w_sub;
            default: w_temp = w_prev;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 60; i++) r_words[i] <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else if (w_clear) begin
            for (int i = 0; i < 60; i++) r_words[i] <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else if (w_load) begin
            for (int i = 0; i < 8; i++) r_words[i] <= key[255-32*i -: 32];
            if (CLEAR_ON_LOAD != 0) begin
                for (int i = 8; i < 60; i++) r_words[i] <= '0;
            end
            r_idx        <= c_IDX_FIRST;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
        end else if (w_step) begin
            r_words[r_idx] <= r_words[w_back_idx] ^ w_temp;
            r_idx          <= r_idx + 6'd1;
            if (w_done) begin
                r_busy       <= 1'b0;
                r_keys_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output packing: word j lands in round key j/4, w4i in the top lane
    // ------------------------------------------------------------------
    for (genvar j = 0; j < 60; j++) begin : g_flat
        assign round_keys_flat[128*(j/4) + 32*(3-(j%4)) +: 32] = r_words[j];
    end

    assign keys_valid = r_keys_valid;
    assign busy       = r_busy;

endmodule
`default_nettype wire
